// File: rtl/config_seq_pkg.sv
// Shared FSM state encoding and default parameter values for the
// configuration word sequencer.
package config_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RELEASE,
    S_GAP,
    S_FIN
  } state_e;

  localparam int DEF_NO_CFG_BITS    = 24;
  localparam int DEF_NO_WORDS       = 8;
  localparam int DEF_GAP_CYCLES     = 48;
  localparam int DEF_TIMEOUT_CYCLES = 2400000;

endpackage

// File: rtl/config_seq_tbl.sv
// Word table for config_seq: synchronous write, registered read port that
// only updates on rd_en_i, whole table cleared by asynchronous reset.
module config_seq_tbl #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register doubles as the word presented to the transmitter,
  // so it must hold its value between loads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/config_seq.sv
// Sends the first NUM_WORDS table entries to a config transmitter with a fixed
// idle gap between words. Define CONFIG_SEQ_TIMEOUT_EN to add a handshake watchdog.
module config_seq
  import config_seq_pkg::*;
#(
  parameter int C_NO_CFG_BITS    = DEF_NO_CFG_BITS,
  parameter int C_NO_WORDS       = DEF_NO_WORDS,
  parameter int C_GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int C_TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          GO,
  input  logic [$clog2(C_NO_WORDS):0]   NUM_WORDS,
  input  logic                          WR_EN,
  input  logic [$clog2(C_NO_WORDS)-1:0] WR_ADDR,
  input  logic [C_NO_CFG_BITS-1:0]      WR_DATA,
  output logic                          CFG_START,
  output logic [C_NO_CFG_BITS-1:0]      CFG_DATA,
  input  logic                          CFG_END,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR
);

  localparam int AW = $clog2(C_NO_WORDS);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(C_GAP_CYCLES) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   index_q, index_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   eff_count;
  logic [CW-1:0]   index_next;
  logic            gap_done;
  logic            tbl_rd_en;
  logic            tbl_wr_en;
  logic            wd_expired;

  assign eff_count  = (NUM_WORDS > CW'(C_NO_WORDS)) ? CW'(C_NO_WORDS) : NUM_WORDS;
  assign index_next = index_q + CW'(1);
  assign gap_done   = (gap_cnt_q == GW'(C_GAP_CYCLES - 1));
  assign tbl_wr_en  = WR_EN && !busy_q;

  config_seq_tbl #(
    .W     (C_NO_CFG_BITS),
    .DEPTH (C_NO_WORDS),
    .AW    (AW)
  ) u_tbl (
    .clk_i     (CLOCK),
    .rst_i     (RESET),
    .wr_en_i   (tbl_wr_en),
    .wr_addr_i (WR_ADDR),
    .wr_data_i (WR_DATA),
    .rd_en_i   (tbl_rd_en),
    .rd_addr_i (index_q[AW-1:0]),
    .rd_data_o (CFG_DATA)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      count_q   <= '0;
      gap_cnt_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      count_q   <= count_d;
      gap_cnt_q <= gap_cnt_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // A zero effective count skips straight to FIN so DONE still pulses.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (GO) state_d = (eff_count == '0) ? S_FIN : S_LOAD;
      S_LOAD:    state_d = S_REQ;
      S_REQ: begin
        if (CFG_END)         state_d = S_RELEASE;
        else if (wd_expired) state_d = S_FIN;
      end
      S_RELEASE: begin
        if (!CFG_END)        state_d = S_GAP;
        else if (wd_expired) state_d = S_FIN;
      end
      S_GAP:     if (gap_done) state_d = (index_next < count_q) ? S_LOAD : S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    index_d   = index_q;
    count_d   = count_q;
    gap_cnt_d = '0;
    tbl_rd_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (GO) begin
          index_d = '0;
          count_d = eff_count;
        end
      end
      S_LOAD: tbl_rd_en = 1'b1;
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_done) index_d = index_next;
      end
      default: ;
    endcase
    start_d = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_FIN);
  end

`ifdef CONFIG_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(C_TIMEOUT_CYCLES) + 1;

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           err_q, err_d;
  logic           waiting;

  assign waiting    = (state_q == S_REQ) || (state_q == S_RELEASE);
  assign wd_expired = waiting && (wd_cnt_q >= WDW'(C_TIMEOUT_CYCLES - 1));

  // Counter saturates at the limit so a late expiry cannot wrap and be missed.
  always_comb begin
    wd_cnt_d = '0;
    if (waiting) wd_cnt_d = wd_expired ? wd_cnt_q : wd_cnt_q + WDW'(1);
    err_d = err_q;
    if (state_q == S_IDLE && GO)          err_d = 1'b0;
    else if (waiting && state_d == S_FIN) err_d = 1'b1;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign wd_expired = 1'b0;
  assign ERR        = 1'b0;
`endif

  assign CFG_START = start_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_config_seq.sv
// Directed testbench for config_seq with a behavioural transmitter responder.
// Covers the watchdog path when CONFIG_SEQ_TIMEOUT_EN is defined.
module tb_config_seq;

  localparam int AW = 3;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          GO;
  logic [AW:0]   NUM_WORDS;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [23:0]   WR_DATA;
  logic          CFG_START;
  logic [23:0]   CFG_DATA;
  logic          CFG_END;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  int errors = 0;
  int checks = 0;

  // Responder control: 0 = auto handshake after endDelay cycles, 1 = hold high, 2 = hold low.
  int respMode = 0;
  int endDelay = 480;
  int respCnt  = 0;

  logic [23:0] words[$];
  int          gaps[$];
  int          startRises = 0;
  int          doneCount  = 0;
  int          lowRun     = 0;
  logic        prevStart  = 1'b0;

  config_seq #(
    .C_NO_CFG_BITS    (24),
    .C_NO_WORDS       (8),
    .C_GAP_CYCLES     (48),
    .C_TIMEOUT_CYCLES (100)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .GO        (GO),
    .NUM_WORDS (NUM_WORDS),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .CFG_START (CFG_START),
    .CFG_DATA  (CFG_DATA),
    .CFG_END   (CFG_END),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #10 CLOCK = ~CLOCK;

  // Transmitter model: raises CFG_END a fixed delay after CFG_START, drops it once CFG_START falls.
  initial begin
    CFG_END = 1'b0;
    forever begin
      @(posedge CLOCK);
      #2;
      case (respMode)
        1: begin CFG_END = 1'b1; respCnt = 0; end
        2: begin CFG_END = 1'b0; respCnt = 0; end
        default: begin
          if (!CFG_START) begin
            respCnt = 0;
            CFG_END = 1'b0;
          end else if (!CFG_END) begin
            if (respCnt >= endDelay) CFG_END = 1'b1;
            else respCnt++;
          end
        end
      endcase
    end
  end

  // Records every transmitted word, the idle run before it and DONE pulses.
  always @(negedge CLOCK) begin
    if (CFG_START && !prevStart) begin
      words.push_back(CFG_DATA);
      gaps.push_back(lowRun);
      startRises++;
    end
    if (CFG_START) lowRun = 0;
    else lowRun++;
    prevStart = CFG_START;
    if (DONE) doneCount++;
  end

  task automatic writeWord(input logic [AW-1:0] a, input logic [23:0] d);
    @(negedge CLOCK);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    @(negedge CLOCK);
    WR_EN = 1'b0;
  endtask

  task automatic pulseGo(input logic [AW:0] n);
    @(negedge CLOCK);
    GO = 1'b1; NUM_WORDS = n;
    @(negedge CLOCK);
    GO = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLOCK);
      if (DONE) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; GO = 1'b0; NUM_WORDS = '0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    repeat (3) @(negedge CLOCK);
    checks++;
    if ({CFG_START, BUSY, DONE, ERR} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {CFG_START, BUSY, DONE, ERR});
    end
    checks++;
    if (CFG_DATA !== 24'h000000) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 000000", CFG_DATA);
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release_busy: got %b expected 0", BUSY);
    end
  endtask

  task automatic test_basic();
    int w0, r0, d0;
    bit seen;
    writeWord(0, 24'hAEC9EC);
    writeWord(1, 24'h123456);
    respMode = 0; endDelay = 480;
    w0 = words.size(); r0 = startRises; d0 = doneCount;
    pulseGo(2);
    checks++;
    if ({CFG_START, BUSY} !== 2'b01) begin
      errors++; $display("[TB] FAIL basic_load_cycle: start/busy %b expected 01", {CFG_START, BUSY});
    end
    @(negedge CLOCK);
    checks++;
    if (CFG_START !== 1'b1 || CFG_DATA !== 24'hAEC9EC) begin
      errors++; $display("[TB] FAIL basic_first_req: start %b data %h expected 1 aec9ec", CFG_START, CFG_DATA);
    end
    waitDone(3000, seen);
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL basic_done_timeout: done not seen, expected within 3000 cycles");
    end
    @(negedge CLOCK);
    checks++;
    if (startRises - r0 !== 2) begin
      errors++; $display("[TB] FAIL basic_start_count: got %0d expected 2", startRises - r0);
    end
    checks++;
    if (words[w0] !== 24'hAEC9EC) begin
      errors++; $display("[TB] FAIL basic_word0: got %h expected aec9ec", words[w0]);
    end
    checks++;
    if (words[w0+1] !== 24'h123456) begin
      errors++; $display("[TB] FAIL basic_word1: got %h expected 123456", words[w0+1]);
    end
    checks++;
    if (gaps[w0+1] < 48 || gaps[w0+1] > 52) begin
      errors++; $display("[TB] FAIL basic_gap: got %0d cycles expected 48..52", gaps[w0+1]);
    end
    checks++;
    if (doneCount - d0 !== 1) begin
      errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCount - d0);
    end
    checks++;
    if ({ERR, BUSY} !== 2'b00) begin
      errors++; $display("[TB] FAIL basic_end_flags: err/busy %b expected 00", {ERR, BUSY});
    end
  endtask

  task automatic test_empty();
    int r0;
    r0 = startRises;
    pulseGo(0);
    checks++;
    if ({DONE, BUSY} !== 2'b01) begin
      errors++; $display("[TB] FAIL empty_cycle1: done/busy %b expected 01", {DONE, BUSY});
    end
    @(negedge CLOCK);
    checks++;
    if ({DONE, BUSY} !== 2'b10) begin
      errors++; $display("[TB] FAIL empty_cycle2: done/busy %b expected 10", {DONE, BUSY});
    end
    @(negedge CLOCK);
    checks++;
    if (DONE !== 1'b0) begin
      errors++; $display("[TB] FAIL empty_done_width: got %b expected 0", DONE);
    end
    checks++;
    if (startRises !== r0) begin
      errors++; $display("[TB] FAIL empty_no_start: got %0d starts expected 0", startRises - r0);
    end
  endtask

  task automatic test_busy_ignore();
    int w0, d0;
    bit seen;
    respMode = 0; endDelay = 20;
    w0 = words.size(); d0 = doneCount;
    pulseGo(1);
    repeat (5) @(negedge CLOCK);
    writeWord(0, 24'h0BAD00);
    pulseGo(1);
    waitDone(500, seen);
    repeat (80) @(negedge CLOCK);
    checks++;
    if (words.size() - w0 !== 1 || doneCount - d0 !== 1) begin
      errors++; $display("[TB] FAIL busy_go_ignored: words %0d dones %0d expected 1 1", words.size() - w0, doneCount - d0);
    end
    checks++;
    if (words[w0] !== 24'hAEC9EC) begin
      errors++; $display("[TB] FAIL busy_word: got %h expected aec9ec", words[w0]);
    end
    pulseGo(1);
    waitDone(500, seen);
    @(negedge CLOCK);
    checks++;
    if (words[w0+1] !== 24'hAEC9EC) begin
      errors++; $display("[TB] FAIL busy_table_kept: got %h expected aec9ec", words[w0+1]);
    end
  endtask

  task automatic test_write_and_go();
    bit seen;
    @(negedge CLOCK);
    WR_EN = 1'b1; WR_ADDR = 0; WR_DATA = 24'h5A5A5A; GO = 1'b1; NUM_WORDS = 1;
    @(negedge CLOCK);
    WR_EN = 1'b0; GO = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (CFG_START !== 1'b1 || CFG_DATA !== 24'h5A5A5A) begin
      errors++; $display("[TB] FAIL write_go_same_cycle: start %b data %h expected 1 5a5a5a", CFG_START, CFG_DATA);
    end
    waitDone(500, seen);
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL write_go_done: done not seen, expected within 500 cycles");
    end
  endtask

  task automatic test_end_already_high();
    bit seen;
    respMode = 1;
    repeat (2) @(negedge CLOCK);
    pulseGo(1);
    @(negedge CLOCK);
    checks++;
    if (CFG_START !== 1'b1) begin
      errors++; $display("[TB] FAIL endhigh_req: start %b expected 1", CFG_START);
    end
    @(negedge CLOCK);
    checks++;
    if ({CFG_START, BUSY} !== 2'b01) begin
      errors++; $display("[TB] FAIL endhigh_release: start/busy %b expected 01", {CFG_START, BUSY});
    end
    repeat (3) @(negedge CLOCK);
    checks++;
    if ({CFG_START, BUSY, DONE} !== 3'b010) begin
      errors++; $display("[TB] FAIL endhigh_wait_low: start/busy/done %b expected 010", {CFG_START, BUSY, DONE});
    end
    respMode = 0;
    waitDone(200, seen);
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL endhigh_done: done not seen, expected within 200 cycles");
    end
  endtask

  task automatic test_reset_midseq();
    int w0, d0;
    bit seen;
    writeWord(0, 24'h777777);
    respMode = 0; endDelay = 480;
    d0 = doneCount;
    pulseGo(1);
    @(negedge CLOCK);
    repeat (240) @(negedge CLOCK);
    checks++;
    if (CFG_START !== 1'b1) begin
      errors++; $display("[TB] FAIL midseq_in_req: start %b expected 1", CFG_START);
    end
    #3 RESET = 1'b1;
    #1;
    checks++;
    if ({CFG_START, BUSY} !== 2'b00 || CFG_DATA !== 24'h000000) begin
      errors++; $display("[TB] FAIL midseq_async_clear: start/busy %b data %h expected 00 000000", {CFG_START, BUSY}, CFG_DATA);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    repeat (60) @(negedge CLOCK);
    checks++;
    if (doneCount !== d0) begin
      errors++; $display("[TB] FAIL midseq_no_done: got %0d dones expected 0", doneCount - d0);
    end
    endDelay = 5;
    w0 = words.size();
    pulseGo(1);
    waitDone(300, seen);
    @(negedge CLOCK);
    checks++;
    if (words.size() - w0 !== 1 || words[w0] !== 24'h000000) begin
      errors++; $display("[TB] FAIL midseq_zeroed_table: %0d words first %h expected 1 000000", words.size() - w0, words[w0]);
    end
  endtask

  task automatic test_clamp();
    int w0, d0;
    bit seen;
    logic [23:0] expWord;
    for (int i = 0; i < 8; i++) writeWord(AW'(i), 24'hC00000 + 24'(i));
    respMode = 0; endDelay = 5;
    w0 = words.size(); d0 = doneCount;
    pulseGo(15);
    waitDone(3000, seen);
    @(negedge CLOCK);
    checks++;
    if (words.size() - w0 !== 8 || doneCount - d0 !== 1) begin
      errors++; $display("[TB] FAIL clamp_count: words %0d dones %0d expected 8 1", words.size() - w0, doneCount - d0);
    end
    for (int i = 0; i < 8; i++) begin
      expWord = 24'hC00000 + 24'(i);
      checks++;
      if (words[w0+i] !== expWord) begin
        errors++; $display("[TB] FAIL clamp_word%0d: got %h expected %h", i, words[w0+i], expWord);
      end
    end
  endtask

`ifdef CONFIG_SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    int highCnt;
    bit seen;
    respMode = 2;
    repeat (2) @(negedge CLOCK);
    pulseGo(1);
    highCnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK);
      if (CFG_START) highCnt++;
      else if (highCnt > 0) break;
    end
    checks++;
    if (highCnt !== 100) begin
      errors++; $display("[TB] FAIL wd_req_cycles: got %0d expected 100", highCnt);
    end
    checks++;
    if ({ERR, BUSY} !== 2'b11) begin
      errors++; $display("[TB] FAIL wd_err_set: err/busy %b expected 11", {ERR, BUSY});
    end
    @(negedge CLOCK);
    checks++;
    if ({DONE, BUSY, ERR} !== 3'b101) begin
      errors++; $display("[TB] FAIL wd_done: done/busy/err %b expected 101", {DONE, BUSY, ERR});
    end
    respMode = 0;
    pulseGo(0);
    checks++;
    if (ERR !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_err_cleared: got %b expected 0", ERR);
    end
    waitDone(10, seen);
  endtask
`else
  task automatic test_watchdog();
    bit seen;
    respMode = 2;
    repeat (2) @(negedge CLOCK);
    pulseGo(1);
    repeat (150) @(negedge CLOCK);
    checks++;
    if ({CFG_START, BUSY, ERR} !== 3'b110) begin
      errors++; $display("[TB] FAIL nowd_waits: start/busy/err %b expected 110", {CFG_START, BUSY, ERR});
    end
    respMode = 0; endDelay = 5;
    waitDone(200, seen);
    checks++;
    if (!seen || ERR !== 1'b0) begin
      errors++; $display("[TB] FAIL nowd_finish: done %b err %b expected 1 0", seen, ERR);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_busy_ignore();
    test_write_and_go();
    test_end_already_high();
    test_reset_midseq();
    test_clamp();
    test_watchdog();
    repeat (2) @(negedge CLOCK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_seq.md
CONFIG_SEQ -- requirements
Module: config_seq

Interface
REQ-001 Parameter C_NO_CFG_BITS, default 24, width of one configuration word (equals the transmitter's C_NO_CFG_BITS).
REQ-002 Parameter C_NO_WORDS, default 8, depth of the word table (power of two, 2..64).
REQ-003 Parameter C_GAP_CYCLES, default 48, idle CLOCK cycles between consecutive words (1 us at 48 MHz).
REQ-004 Parameter C_TIMEOUT_CYCLES, default 2400000, watchdog limit per word handshake (50 ms at 48 MHz).
REQ-005 CLOCK  in  1  system clock, 48 MHz nominal.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 GO  in  1  single-cycle request to transmit the table.
REQ-008 NUM_WORDS  in  clog2(C_NO_WORDS)+1  number of words to send, starting at address 0.
REQ-009 WR_EN  in  1  table write strobe.
REQ-010 WR_ADDR  in  clog2(C_NO_WORDS)  table write address.
REQ-011 WR_DATA  in  C_NO_CFG_BITS  table write data.
REQ-012 CFG_START  out  1  level start request to the config transmitter.
REQ-013 CFG_DATA  out  C_NO_CFG_BITS  word presented to transmitter INPUT.
REQ-014 CFG_END  in  1  transmitter TX_END, high when the word has been shifted out.
REQ-015 BUSY  out  1  high from GO acceptance until sequence finish.
REQ-016 DONE  out  1  one-cycle pulse on sequence completion.
REQ-017 ERR  out  1  sticky watchdog error flag.

Function
REQ-018 FSM states: IDLE, LOAD, REQ, RELEASE, GAP, FIN; all outputs registered.
REQ-019 IDLE: GO=1 with BUSY=0 -> LOAD, index cleared to 0, BUSY=1 next cycle, ERR cleared.
REQ-020 LOAD: CFG_DATA <= table[index]; -> REQ next cycle (1-cycle latency GO->CFG_START).
REQ-021 REQ: CFG_START=1, held until CFG_END sampled 1, then CFG_START=0 and -> RELEASE.
REQ-022 RELEASE: wait for CFG_END=0, then -> GAP; CFG_DATA held stable through REQ and RELEASE.
REQ-023 GAP: count C_GAP_CYCLES; at terminal count index+1; if index+1 < effective count -> LOAD, else -> FIN.
REQ-024 FIN: DONE=1 for exactly one cycle, BUSY=0 same cycle, -> IDLE.
REQ-025 Effective count = min(NUM_WORDS, C_NO_WORDS), sampled at GO acceptance; NUM_WORDS=0 -> LOAD skipped, FIN directly (DONE 2 cycles after GO, no CFG_START).
REQ-026 GO while BUSY=1 ignored, not queued.
REQ-027 WR_EN accepted only when BUSY=0; writes during BUSY dropped; table stable during a sequence.
REQ-028 WR_EN and GO in the same IDLE cycle: write commits first; sequence transmits the new word.
REQ-029 CFG_END already high at REQ entry: treated as completion on the first REQ cycle (level-sampled).

Reset
REQ-030 RESET=1 forces IDLE, index 0, table all zeros, CFG_START=0, CFG_DATA=0, BUSY=0, DONE=0, ERR=0, asynchronously.
REQ-031 Reset mid-sequence drops CFG_START immediately; no DONE is generated for the aborted sequence.

Configuration
REQ-032 Macro CONFIG_SEQ_TIMEOUT_EN defined: watchdog counts CLOCK cycles in REQ plus RELEASE; reaching C_TIMEOUT_CYCLES sets ERR=1, CFG_START=0, -> FIN (DONE pulse still issued).
REQ-033 Macro undefined: no watchdog counter, ERR tied 0, REQ/RELEASE wait indefinitely.

Structure
REQ-034 Package config_seq_pkg holds FSM state enumeration and default parameter constants.
REQ-035 Table is sub-module config_seq_tbl: synchronous write, registered read, async reset clear.

Verification
REQ-036 Write 0xAEC9EC to addr 0, 0x123456 to addr 1, NUM_WORDS=2, GO; CFG_END model returns 1 after 10 us -> CFG_DATA 0xAEC9EC then 0x123456, two CFG_START pulses separated by >=48-cycle gap, single DONE, ERR=0.
REQ-037 NUM_WORDS=0, GO -> no CFG_START, DONE exactly 2 cycles after GO.
REQ-038 GO repeated and WR_EN to addr 0 during BUSY -> ignored; table readback and transmitted word unchanged.
REQ-039 RESET asserted 5 us into REQ -> CFG_START, BUSY low within the reset cycle; no DONE; next GO restarts at index 0 with zeroed table.
REQ-040 With CONFIG_SEQ_TIMEOUT_EN and C_TIMEOUT_CYCLES=100, CFG_END held 0 -> ERR=1 and DONE after 100 cycles in REQ; next GO clears ERR.
REQ-041 NUM_WORDS=15 with C_NO_WORDS=8 -> exactly 8 words transmitted, addresses 0..7.
